// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl -- sequencer/arbiter for the shared register bus.
// Several requesters ask for register-to-register transfers. One transfer is
// granted at a time. For that transfer the block drives Oen (the source drives
// the bus) and then Inen (the destination latches the bus). At most one
// register drives the bus in any cycle.
//
// Optional feature: define BUS_XFER_RR_EN for round-robin arbitration.
// When it is undefined, arbitration is fixed priority (the lowest index wins).
//
// Ports:
//   clk            rising-edge clock
//   clr            asynchronous reset, active low
//   req  [NREQ]    level request per requester
//   src  [NREQ*IW] source index, requester i in bits [i*IW +: IW]
//   dst  [NREQ*IW] destination index, same packing
//   grant[NREQ]    one-hot, the requester being served
//   busy           high whenever the FSM is not idle
//   done           one-cycle completion pulse
//   err            one-cycle pulse with done for a rejected transfer
//   Oen  [NREG]    per-register bus drive enable
//   Inen [NREG]    per-register latch enable
module bus_xfer_ctrl #(
  parameter  int NREG = 4,
  parameter  int NREQ = 2,
  localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int RW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*IW-1:0] src,
  input  logic [NREQ*IW-1:0] dst,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NREG-1:0]   Oen,
  output logic [NREG-1:0]   Inen
);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, FIN, REJ} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   src_q, dst_q;
  logic [IW-1:0]   win_src, win_dst;
  logic [RW-1:0]   win, cand;
  logic            win_vld, win_ok;
  logic [NREQ-1:0] grant_q;
`ifdef BUS_XFER_RR_EN
  logic [RW-1:0]   rr_ptr;   // next requester to be searched first
`endif

  // Arbiter: scan requesters in priority order and take the first one asking.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef BUS_XFER_RR_EN
      cand = RW'((int'(rr_ptr) + k) % NREQ);
`else
      cand = RW'(k);
`endif
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  assign win_src = src[int'(win)*IW +: IW];
  assign win_dst = dst[int'(win)*IW +: IW];
  assign win_ok  = (win_src != win_dst) && (int'(win_src) < NREG) && (int'(win_dst) < NREG);

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (win_vld) state_nxt = win_ok ? SETUP : REJ;
      SETUP:    state_nxt = LOAD;
      LOAD:     state_nxt = FIN;
      FIN, REJ: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Capture the winner's indices in IDLE. Later changes on src/dst are ignored.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      grant_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
`ifdef BUS_XFER_RR_EN
      rr_ptr  <= '0;
`endif
    end else if (state == IDLE && win_vld) begin
      grant_q <= NREQ'(1) << win;
      src_q   <= win_src;
      dst_q   <= win_dst;
`ifdef BUS_XFER_RR_EN
      rr_ptr  <= RW'((int'(win) + 1) % NREQ);
`endif
    end else if (state == FIN || state == REJ) begin
      grant_q <= '0;
    end
  end

  // Outputs: decoded only from the state and the captured registers.
  // No combinational path exists from req/src/dst to any output.
  always_comb begin
    Oen   = '0;
    Inen  = '0;
    done  = 1'b0;
    err   = 1'b0;
    busy  = (state != IDLE);
    grant = grant_q;
    case (state)
      SETUP: Oen[src_q] = 1'b1;
      LOAD: begin
        Oen[src_q]  = 1'b1;
        Inen[dst_q] = 1'b1;
      end
      FIN:  done = 1'b1;
      REJ: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Testbench for bus_xfer_ctrl. It uses a transaction-level reference model and
// a behavioural register bank connected to the Oen/Inen strobes.
// A second instance with NREG=5 exercises source indices beyond NREG.
module tb_bus_xfer_ctrl;
  localparam int NREG = 4;
  localparam int NREQ = 2;
  localparam int IW   = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] req = '0;
  logic [3:0] src = '0, dst = '0;
  logic [1:0] grant;
  logic       busy, done, err;
  logic [3:0] Oen, Inen;

  logic [1:0] req5 = '0;
  logic [5:0] src5 = '0, dst5 = '0;
  logic [1:0] grant5;
  logic       busy5, done5, err5;
  logic [4:0] Oen5, Inen5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.NREG(4), .NREQ(2)) dut (
    .clk(clk), .clr(clr), .req(req), .src(src), .dst(dst),
    .grant(grant), .busy(busy), .done(done), .err(err), .Oen(Oen), .Inen(Inen));

  bus_xfer_ctrl #(.NREG(5), .NREQ(2)) dut5 (
    .clk(clk), .clr(clr), .req(req5), .src(src5), .dst(dst5),
    .grant(grant5), .busy(busy5), .done(done5), .err(err5), .Oen(Oen5), .Inen(Inen5));

  // Register bank driven by the DUT strobes
  logic [3:0] bank [4] = '{4'h5, 4'hA, 4'h3, 4'hC};
  logic [3:0] bus;
  always_comb begin
    bus = '0;
    for (int i = 0; i < 4; i++) if (Oen[i]) bus = bus | bank[i];
  end
  always @(posedge clk) for (int i = 0; i < 4; i++) if (Inen[i]) bank[i] <= bus;

  logic [12:0] obs;
  assign obs = {grant, busy, done, err, Oen, Inen};
  logic [16:0] obs5;
  assign obs5 = {grant5, busy5, done5, err5, Oen5, Inen5};

  // Reference model: each granted transfer becomes a timeline of expected
  // output words, one word per clock edge.
  typedef struct { logic [12:0] w; bit cp; int s; int d; } ent_t;
  ent_t        q[$];
  int          ptr = 0;
  logic [3:0]  ref_bank [4] = '{4'h5, 4'hA, 4'h3, 4'hC};
  logic [12:0] exp_w = '0;

  function automatic logic [12:0] mk(logic [1:0] g, logic b, logic dn, logic e,
                                     logic [3:0] o, logic [3:0] i);
    return {g, b, dn, e, o, i};
  endfunction

  task automatic model_edge();
    int w, s, d, c;
    logic [1:0] g;
    ent_t e;
    if (q.size() == 0 && req != 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
`ifdef BUS_XFER_RR_EN
        c = (ptr + k) % NREQ;
`else
        c = k;
`endif
        if (w < 0 && req[c]) w = c;
      end
      ptr = (w + 1) % NREQ;
      s = int'(src[w*IW +: IW]);
      d = int'(dst[w*IW +: IW]);
      g = 2'(1 << w);
      e.cp = 0; e.s = s; e.d = d;
      if (s != d && s < NREG && d < NREG) begin
        e.w = mk(g, 1'b1, 1'b0, 1'b0, 4'(1 << s), 4'b0);     q.push_back(e);
        e.w = mk(g, 1'b1, 1'b0, 1'b0, 4'(1 << s), 4'(1 << d)); q.push_back(e);
        e.w = mk(g, 1'b1, 1'b1, 1'b0, 4'b0, 4'b0); e.cp = 1;  q.push_back(e);
        e.w = '0; e.cp = 0;                                  q.push_back(e);
      end else begin
        e.w = mk(g, 1'b1, 1'b1, 1'b1, 4'b0, 4'b0); q.push_back(e);
        e.w = '0;                                  q.push_back(e);
      end
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      exp_w = e.w;
      if (e.cp) ref_bank[e.d] = ref_bank[e.s];
    end else begin
      exp_w = '0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    ptr   = 0;
    exp_w = '0;
  endtask

  task automatic pulse_reset();
    clr = 1'b0;
    #1;
    model_reset();
    clr = 1'b1;
  endtask

  task automatic drain();
    req = '0;
    for (int n = 0; n < 4; n++) step();
  endtask

  task automatic test_reset();
    #1 clr = 1'b0;
    #1;
    total++; if (obs !== 13'h0) begin bad++; $display("FAIL reset_out: got %h want 0", obs); end
    total++; if (obs5 !== 17'h0) begin bad++; $display("FAIL reset_out5: got %h want 0", obs5); end
    model_reset();
    #1 clr = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      total++; if (obs !== exp_w) begin bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_w); end
    end
  endtask

  task automatic test_single();
    req = 2'b01; src = 4'b0001; dst = 4'b0011;
    step();
    req = 2'b00;
    total++; if (obs !== exp_w) begin bad++; $display("FAIL single_setup_model: got %h want %h", obs, exp_w); end
    total++; if ({grant, busy, Oen, Inen} !== {2'b01, 1'b1, 4'b0010, 4'b0000}) begin
      bad++; $display("FAIL single_setup: got g=%b b=%b o=%b i=%b", grant, busy, Oen, Inen); end
    step();
    total++; if ({Oen, Inen} !== {4'b0010, 4'b1000}) begin
      bad++; $display("FAIL single_load: got o=%b i=%b want 0010 1000", Oen, Inen); end
    step();
    total++; if ({done, err, Oen, Inen} !== 10'b10_0000_0000) begin
      bad++; $display("FAIL single_done: got d=%b e=%b o=%b i=%b", done, err, Oen, Inen); end
    step();
    total++; if (obs !== 13'h0) begin bad++; $display("FAIL single_idle: got %h want 0", obs); end
    total++; if (bank[3] !== 4'hA || ref_bank[3] !== 4'hA) begin
      bad++; $display("FAIL single_data: got %h want a", bank[3]); end
  endtask

  task automatic test_invalid();
    req = 2'b01; src = 4'b0010; dst = 4'b0010;
    step();
    req = 2'b00;
    total++; if (obs !== mk(2'b01, 1'b1, 1'b1, 1'b1, 4'b0, 4'b0)) begin
      bad++; $display("FAIL invalid_same: got %h want %h", obs, mk(2'b01, 1'b1, 1'b1, 1'b1, 4'b0, 4'b0)); end
    step();
    total++; if (obs !== exp_w || obs !== 13'h0) begin bad++; $display("FAIL invalid_same_idle: got %h want 0", obs); end
    // out-of-range source on the NREG=5 instance
    req5 = 2'b01; src5 = 6'd5; dst5 = 6'd1;
    step();
    req5 = 2'b00;
    total++; if (obs5 !== {2'b01, 3'b111, 5'b0, 5'b0}) begin
      bad++; $display("FAIL invalid_range: got %h want %h", obs5, {2'b01, 3'b111, 5'b0, 5'b0}); end
    step();
    total++; if (obs5 !== 17'h0) begin bad++; $display("FAIL invalid_range_idle: got %h want 0", obs5); end
    // highest legal index on the same instance goes through
    req5 = 2'b10; src5 = {3'd4, 3'd0}; dst5 = {3'd0, 3'd0};
    step();
    req5 = 2'b00;
    total++; if ({grant5, Oen5, Inen5} !== {2'b10, 5'b10000, 5'b00000}) begin
      bad++; $display("FAIL range_ok_setup: got %h", {grant5, Oen5, Inen5}); end
    step();
    total++; if ({Oen5, Inen5} !== {5'b10000, 5'b00001}) begin
      bad++; $display("FAIL range_ok_load: got %h want 201", {Oen5, Inen5}); end
    step(); step();
  endtask

  task automatic test_contention();
    logic [1:0] gl[$];
    logic [1:0] eg [4];
    logic pb;
`ifdef BUS_XFER_RR_EN
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    eg = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    drain();
    pulse_reset();
    pb  = 1'b0;
    req = 2'b11; src = {2'd2, 2'd0}; dst = {2'd3, 2'd1};
    for (int n = 0; n < 16; n++) begin
      step();
      total++; if (obs !== exp_w) begin bad++; $display("FAIL contention_model: cyc %0d got %h want %h", n, obs, exp_w); end
      if (busy && !pb) gl.push_back(grant);
      pb = busy;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= gl.size()) begin bad++; $display("FAIL contention_grant%0d: got none want %b", i, eg[i]); end
      else if (gl[i] !== eg[i]) begin bad++; $display("FAIL contention_grant%0d: got %b want %b", i, gl[i], eg[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int dc[$];
    drain();
    req = 2'b01; src = 4'b0010; dst = 4'b0000;
    for (int n = 0; n < 12; n++) begin
      step();
      total++; if (obs !== exp_w) begin bad++; $display("FAIL b2b_model: cyc %0d got %h want %h", n, obs, exp_w); end
      if (done) dc.push_back(n);
    end
    total++;
    if (dc.size() < 2) begin bad++; $display("FAIL b2b_period: got %0d done pulses want >=2", dc.size()); end
    else if (dc[1] - dc[0] != 4) begin bad++; $display("FAIL b2b_period: got %0d want 4", dc[1] - dc[0]); end
  endtask

  task automatic test_mid_change();
    drain();
    req = 2'b01; src = 4'b0000; dst = 4'b0010;
    step();
    total++; if (Oen !== 4'b0001) begin bad++; $display("FAIL mid_setup: got o=%b want 0001", Oen); end
    req = 2'b00; src = 4'b0011; dst = 4'b0001;
    step();
    total++; if (obs !== exp_w || {Oen, Inen} !== 8'b0001_0100) begin
      bad++; $display("FAIL mid_load: got o=%b i=%b want 0001 0100", Oen, Inen); end
    step(); step();
    total++; if (bank[2] !== ref_bank[2] || bank[2] !== bank[0]) begin
      bad++; $display("FAIL mid_data: got %h want %h", bank[2], ref_bank[2]); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] keep;
    drain();
    keep = bank[2];
    req = 2'b01; src = 4'b0001; dst = 4'b0010;
    step();
    req = 2'b00;
    step();
    total++; if (Inen !== 4'b0100) begin bad++; $display("FAIL rmid_load: got i=%b want 0100", Inen); end
    #2 clr = 1'b0;
    #1;
    total++; if (obs !== 13'h0) begin bad++; $display("FAIL rmid_async: got %h want 0", obs); end
    model_reset();
    for (int n = 0; n < 2; n++) begin
      step();
      total++; if (obs !== 13'h0) begin bad++; $display("FAIL rmid_held: got %h want 0", obs); end
    end
    #2 clr = 1'b1;
    step();
    total++; if (obs !== exp_w || busy !== 1'b0) begin bad++; $display("FAIL rmid_idle: got %h want %h", obs, exp_w); end
    total++; if (bank[2] !== keep) begin bad++; $display("FAIL rmid_data: got %h want %h", bank[2], keep); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      req = 2'($urandom_range(0, 3));
      src = 4'($urandom);
      dst = 4'($urandom);
      step();
      total++; if (obs !== exp_w) begin bad++; $display("FAIL rand_model: cyc %0d got %h want %h", n, obs, exp_w); end
      total++;
      if ($countones(Oen) > 1 || $countones(Inen) > 1 || (Oen & Inen) != 0 || (Inen != 0 && Oen == 0)) begin
        bad++; $display("FAIL rand_safety: cyc %0d got o=%b i=%b", n, Oen, Inen); end
      if (q.size() == 0) begin
        for (int i = 0; i < 4; i++) begin
          total++; if (bank[i] !== ref_bank[i]) begin
            bad++; $display("FAIL rand_data: cyc %0d reg %0d got %h want %h", n, i, bank[i], ref_bank[i]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_invalid();
    test_contention();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
